// File: rtl/dmem_arbiter.sv
// Two-requester (cpu, dma) data-memory arbiter.
// One transaction at a time: a grant in IDLE, the memory access in ACCESS,
// and the response in RESP.
// RV32 size codes are checked for alignment when the request is latched.
// A misaligned access or a 64-bit access never touches memory.
//
// state  | meaning
// IDLE   | arbitrating; req_ready goes to the winner
// ACCESS | latched request drives memory; a write commits on exit
// RESP   | owner's resp_valid high for one cycle
module dmem_arbiter #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cpu_req_valid,
    output logic                  cpu_req_ready,
    input  logic [DATA_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    input  logic                  cpu_we,
    input  logic [2:0]            cpu_funct3,
    output logic                  cpu_resp_valid,
    output logic [DATA_WIDTH-1:0] cpu_resp_rdata,
    output logic                  cpu_resp_err,
    input  logic                  dma_req_valid,
    output logic                  dma_req_ready,
    input  logic [DATA_WIDTH-1:0] dma_addr,
    input  logic [DATA_WIDTH-1:0] dma_wdata,
    input  logic                  dma_we,
    input  logic [2:0]            dma_funct3,
    output logic                  dma_resp_valid,
    output logic [DATA_WIDTH-1:0] dma_resp_rdata,
    output logic                  dma_resp_err,
    output logic                  mem_wr_en,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [2:0]            mem_funct3,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  busy
);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_DMA = 1'b1;

    state_t                state_q, state_d;
    logic                  last_grant_q;
    logic                  owner_q;
    logic [DATA_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  we_q;
    logic [2:0]            funct3_q;
    logic                  err_q;
    logic [DATA_WIDTH-1:0] cpu_rdata_q, dma_rdata_q;
    logic                  cpu_err_q, dma_err_q;

    logic                  gnt_cpu, gnt_dma, hs;
    logic [DATA_WIDTH-1:0] sel_addr, sel_wdata;
    logic                  sel_we;
    logic [2:0]            sel_funct3;
    logic                  sel_err;
    logic [DATA_WIDTH-1:0] resp_data;

    // Arbitration: a lone requester wins; a tie goes to the one not granted last.
    // Requests are only considered in IDLE, so a grant is also a handshake.
    always_comb begin
        gnt_cpu = 1'b0;
        gnt_dma = 1'b0;
        if (state_q == S_IDLE) begin
            gnt_cpu = cpu_req_valid && (!dma_req_valid || last_grant_q == OWN_DMA);
            gnt_dma = dma_req_valid && (!cpu_req_valid || last_grant_q == OWN_CPU);
        end
        hs         = gnt_cpu || gnt_dma;
        sel_addr   = gnt_dma ? dma_addr   : cpu_addr;
        sel_wdata  = gnt_dma ? dma_wdata  : cpu_wdata;
        sel_we     = gnt_dma ? dma_we     : cpu_we;
        sel_funct3 = gnt_dma ? dma_funct3 : cpu_funct3;
        case (sel_funct3[1:0])
            2'b01:   sel_err = sel_addr[0];
            2'b10:   sel_err = (sel_addr[1:0] != 2'b00);
            2'b11:   sel_err = 1'b1;
            default: sel_err = 1'b0;
        endcase
        resp_data = (!we_q && !err_q) ? mem_rdata : '0;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (hs) state_d = S_ACCESS;
            S_ACCESS: state_d = S_RESP;
            S_RESP:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from state. Ready is gated by rst_n so it stays low
    // while reset is held.
    always_comb begin
        cpu_req_ready  = rst_n && gnt_cpu;
        dma_req_ready  = rst_n && gnt_dma;
        mem_wr_en      = (state_q == S_ACCESS) && we_q && !err_q;
        cpu_resp_valid = (state_q == S_RESP) && (owner_q == OWN_CPU);
        dma_resp_valid = (state_q == S_RESP) && (owner_q == OWN_DMA);
        busy           = (state_q != S_IDLE);
        mem_addr       = addr_q;
        mem_wdata      = wdata_q;
        mem_funct3     = funct3_q;
        cpu_resp_rdata = cpu_rdata_q;
        cpu_resp_err   = cpu_err_q;
        dma_resp_rdata = dma_rdata_q;
        dma_resp_err   = dma_err_q;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Request latch and grant history, both updated on a handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= OWN_CPU;
            owner_q      <= OWN_CPU;
            addr_q       <= '0;
            wdata_q      <= '0;
            we_q         <= 1'b0;
            funct3_q     <= 3'b000;
            err_q        <= 1'b0;
        end else if (hs) begin
            last_grant_q <= gnt_dma;
            owner_q      <= gnt_dma;
            addr_q       <= sel_addr;
            wdata_q      <= sel_wdata;
            we_q         <= sel_we;
            funct3_q     <= sel_funct3;
            err_q        <= sel_err;
        end
    end

    // Per-requester response registers, loaded at ACCESS exit and held after.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_rdata_q <= '0;
            cpu_err_q   <= 1'b0;
            dma_rdata_q <= '0;
            dma_err_q   <= 1'b0;
        end else if (state_q == S_ACCESS) begin
            if (owner_q == OWN_CPU) begin
                cpu_rdata_q <= resp_data;
                cpu_err_q   <= err_q;
            end else begin
                dma_rdata_q <= resp_data;
                dma_err_q   <= err_q;
            end
        end
    end

endmodule
